// File: rtl/gan_host_driver.sv
// Host-side loader for the GAN inference core: streams parameter words into the
// core's write port, waits for completion, and replays the serial result words.
module gan_host_driver #(
    parameter int WIDTH      = 32,
    parameter int N_WORDS    = 77,
    parameter int N_OUT      = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    acc_rst,
    output logic signed [WIDTH-1:0] acc_data_in,
    output logic [7:0]              acc_addr,
    output logic                    acc_we,
    input  logic signed [WIDTH-1:0] acc_data_out,
    input  logic                    acc_data_valid,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS + 1) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(N_WORDS - 1);
    localparam logic [RW-1:0] LAST_RST  = RW'(RST_CYCLES - 1);
    localparam logic [IW-1:0] LAST_OUT  = IW'(N_OUT - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RST_ACC, LOAD, WAIT_LOW, WAIT_EDGE, OUTPUT} state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           word_cnt;
    logic [RW-1:0]           rst_cnt;
    logic [IW-1:0]           out_idx;
    logic [IW-1:0]           nxt_idx;
    logic [TW-1:0]           tick_cnt;
    logic signed [WIDTH-1:0] hist   [N_OUT-1];
    logic signed [WIDTH-1:0] result [N_OUT];
    logic                    take;
    logic                    timed_out;
    logic                    out_xfer;

    assign take      = s_valid && s_ready;
    assign timed_out = (tick_cnt == LAST_TICK);
    assign out_xfer  = m_valid && m_ready;
    assign nxt_idx   = out_idx + 1'b1;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (start) state_next = RST_ACC;
            RST_ACC:   if (rst_cnt == LAST_RST) state_next = LOAD;
            LOAD:      if (take && word_cnt == LAST_WORD) state_next = WAIT_LOW;
            WAIT_LOW:  if (timed_out) state_next = IDLE;
                       else if (!acc_data_valid) state_next = WAIT_EDGE;
            WAIT_EDGE: if (acc_data_valid) state_next = OUTPUT;
                       else if (timed_out) state_next = IDLE;
            OUTPUT:    if (out_xfer && out_idx == LAST_OUT) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_cnt    <= '0;
            rst_cnt     <= '0;
            out_idx     <= '0;
            tick_cnt    <= '0;
            s_ready     <= 1'b0;
            acc_rst     <= 1'b0;
            acc_data_in <= '0;
            acc_addr    <= '0;
            acc_we      <= 1'b0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            for (int k = 0; k < N_OUT - 1; k++) hist[k] <= '0;
            for (int k = 0; k < N_OUT; k++) result[k] <= '0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != IDLE);
            acc_we  <= 1'b0;
            acc_rst <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            // The core's serial outputs arrive one per cycle ahead of the flag.
            hist[0] <= acc_data_out;
            for (int k = 1; k < N_OUT - 1; k++) hist[k] <= hist[k-1];
            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    if (start) begin
                        acc_rst <= 1'b1;
                        rst_cnt <= '0;
                    end
                end
                RST_ACC: begin
                    if (rst_cnt == LAST_RST) begin
                        s_ready <= 1'b1;
                    end else begin
                        acc_rst <= 1'b1;
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (take) begin
                        acc_we      <= 1'b1;
                        acc_addr    <= 8'(word_cnt);
                        acc_data_in <= s_data;
                        word_cnt    <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            s_ready  <= 1'b0;
                            tick_cnt <= '0;
                        end
                    end
                end
                WAIT_LOW: begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (timed_out) begin
                        err     <= 1'b1;
                        acc_rst <= 1'b1;
                    end
                end
                WAIT_EDGE: begin
                    if (acc_data_valid) begin
                        result[N_OUT-1] <= acc_data_out;
                        for (int k = 0; k < N_OUT - 1; k++) result[N_OUT-2-k] <= hist[k];
                        m_data  <= hist[N_OUT-2];
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        out_idx <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (timed_out) begin
                            err     <= 1'b1;
                            acc_rst <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_xfer) begin
                        if (out_idx == LAST_OUT) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            out_idx <= nxt_idx;
                            m_data  <= result[nxt_idx];
                            m_last  <= (nxt_idx == LAST_OUT);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gan_host_driver.sv
// Scoreboard bench for gan_host_driver: expected core writes and result words are
// queued as stimulus is driven and compared as the driver produces them.
module tb_gan_host_driver;
    localparam int WIDTH = 32, N_WORDS = 77, N_OUT = 4, RST_CYCLES = 2, TIMEOUT = 1024;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst, start, s_valid, s_ready, acc_rst, acc_we, acc_data_valid;
    logic m_valid, m_ready, m_last, busy, done, err;
    logic signed [WIDTH-1:0] s_data, acc_data_in, acc_data_out, m_data;
    logic [7:0] acc_addr;

    gan_host_driver #(.WIDTH(WIDTH), .N_WORDS(N_WORDS), .N_OUT(N_OUT),
                      .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .acc_rst(acc_rst), .acc_data_in(acc_data_in),
        .acc_addr(acc_addr), .acc_we(acc_we), .acc_data_out(acc_data_out),
        .acc_data_valid(acc_data_valid), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done), .err(err));

    always #5 clk = ~clk;

    typedef struct { int addr; logic signed [WIDTH-1:0] data; } wr_t;
    typedef struct { logic signed [WIDTH-1:0] data; logic last; } res_t;

    int checks = 0, errors = 0;
    wr_t  exp_wr[$];
    res_t exp_res[$];
    wr_t  mon_w, drv_w;
    res_t mon_r, core_r;

    // job configuration and observations
    int cfg_gap, cfg_mul, cfg_off, cfg_bp_word, cfg_bp_len;
    bit cfg_respond, cfg_poke;
    logic signed [WIDTH-1:0] cfg_y [N_OUT];
    int r_lat, r_wr, r_res, r_done, r_err, r_rst_all, r_wr_cyc, r_err_cyc, r_hold, r_mvalid, r_last_addr;
    logic r_sready_at_last, r_err_rst;
    logic signed [WIDTH-1:0] r_hold_first, r_hold_last;
    bit over, poked, seen, trig;
    int drv_i, drv_c, obs_c, hold;

    always @(negedge clk) begin
        if (acc_we) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%0d data=%0d required no write", acc_addr, acc_data_in);
            end else begin
                mon_w = exp_wr.pop_front();
                if (acc_addr !== 8'(mon_w.addr) || acc_data_in !== mon_w.data) begin
                    errors++;
                    $display("FAIL write addr=%0d data=%0d required addr=%0d data=%0d",
                             acc_addr, acc_data_in, mon_w.addr, mon_w.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            checks++;
            if (exp_res.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected data=%0d required no result", m_data);
            end else begin
                mon_r = exp_res.pop_front();
                if (m_data !== mon_r.data || m_last !== mon_r.last) begin
                    errors++;
                    $display("FAIL result data=%0d last=%0b required data=%0d last=%0b",
                             m_data, m_last, mon_r.data, mon_r.last);
                end
            end
        end
    end

    task automatic run_job();
        r_lat = -1; r_wr = 0; r_res = 0; r_done = 0; r_err = 0; r_rst_all = 0;
        r_wr_cyc = 0; r_err_cyc = 0; r_hold = 0; r_mvalid = 0; r_last_addr = -1;
        r_sready_at_last = 1'b1; r_err_rst = 1'b0; r_hold_first = '0; r_hold_last = '0;
        over = 0; poked = 0; seen = 0; trig = 0; hold = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        fork
            begin
                drv_i = 0; drv_c = 0;
                while (drv_i < N_WORDS && drv_c < BUDGET && !over) begin
                    s_valid = (cfg_gap == 0) ? 1'b1 : ((drv_c % 4 == 0) || (drv_c % 4 == 3));
                    s_data  = drv_i * cfg_mul + cfg_off;
                    start   = 1'b0;
                    if (cfg_poke && !poked && drv_i == 20) begin start = 1'b1; poked = 1; end
                    @(negedge clk);
                    if (s_valid && s_ready) begin
                        drv_w.addr = drv_i; drv_w.data = s_data;
                        exp_wr.push_back(drv_w);
                        drv_i++;
                    end
                    @(posedge clk); #1;
                    drv_c++;
                end
                s_valid = 1'b0; start = 1'b0;
            end
            begin
                if (cfg_respond) begin
                    while (!seen && !over) begin
                        @(negedge clk);
                        if (acc_we && acc_addr == 8'(N_WORDS - 1)) seen = 1;
                    end
                    if (seen) begin
                        repeat (2) @(posedge clk);
                        #1;
                        for (int k = 0; k < N_OUT; k++) begin
                            acc_data_out   = cfg_y[k];
                            acc_data_valid = (k == N_OUT - 1);
                            core_r.data = cfg_y[k]; core_r.last = (k == N_OUT - 1);
                            exp_res.push_back(core_r);
                            @(posedge clk); #1;
                        end
                        @(posedge clk); #1;
                        acc_data_valid = 1'b0; acc_data_out = '0;
                    end
                end
            end
            begin
                while (!over) begin
                    if (hold > 0) begin
                        m_ready = 1'b0; hold--;
                    end else if (!trig && cfg_bp_len > 0 && r_res == cfg_bp_word && m_valid) begin
                        m_ready = 1'b0; hold = cfg_bp_len - 1; trig = 1;
                    end else begin
                        m_ready = 1'b1;
                    end
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end
            begin
                obs_c = 0;
                while (!over) begin
                    @(negedge clk);
                    obs_c++;
                    if (acc_we) begin
                        if (r_lat < 0) r_lat = obs_c;
                        r_wr++; r_wr_cyc = obs_c; r_last_addr = int'(acc_addr);
                        if (acc_addr == 8'(N_WORDS - 1)) r_sready_at_last = s_ready;
                    end
                    if (acc_rst) r_rst_all++;
                    if (m_valid) r_mvalid++;
                    if (m_valid && m_ready) r_res++;
                    if (m_valid && !m_ready) begin
                        if (r_hold == 0) r_hold_first = m_data;
                        r_hold_last = m_data; r_hold++;
                    end
                    if (err) begin r_err++; r_err_cyc = obs_c; r_err_rst = acc_rst; end
                    if (done) r_done++;
                    if (done || err || obs_c >= BUDGET) over = 1;
                end
            end
        join
        if (obs_c >= BUDGET) begin
            checks++; errors++;
            $display("FAIL job_budget cycles=%0d required completion below %0d", obs_c, BUDGET);
        end
    endtask

    task automatic set_cfg(input int gap, input int mul, input int off, input bit respond,
                           input int bp_word, input int bp_len, input bit poke);
        cfg_gap = gap; cfg_mul = mul; cfg_off = off; cfg_respond = respond;
        cfg_bp_word = bp_word; cfg_bp_len = bp_len; cfg_poke = poke;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, acc_rst, acc_we, m_valid, m_last, busy, done, err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=00000000",
                     {s_ready, acc_rst, acc_we, m_valid, m_last, busy, done, err});
        end
        checks++;
        if (acc_addr !== 8'd0 || acc_data_in !== '0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%0d din=%0d mdata=%0d required 0 0 0", acc_addr, acc_data_in, m_data);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start busy=%0b s_ready=%0b required 0 0", busy, s_ready);
        end
    endtask

    task automatic test_basic();
        set_cfg(0, 3, -100, 1, 0, 0, 0);
        cfg_y = '{32'sd5, 32'sd0, 32'sd17, -32'sd1};
        run_job();
        checks++;
        if (r_lat !== RST_CYCLES + 2) begin errors++; $display("FAIL basic_latency got=%0d required=%0d", r_lat, RST_CYCLES + 2); end
        checks++;
        if (r_rst_all !== RST_CYCLES) begin errors++; $display("FAIL basic_acc_rst got=%0d required=%0d", r_rst_all, RST_CYCLES); end
        checks++;
        if (r_wr !== N_WORDS || r_last_addr !== N_WORDS - 1) begin
            errors++; $display("FAIL basic_writes got=%0d last=%0d required=%0d last=%0d", r_wr, r_last_addr, N_WORDS, N_WORDS - 1);
        end
        checks++;
        if (r_sready_at_last !== 1'b0) begin errors++; $display("FAIL basic_sready_drop got=%0b required=0", r_sready_at_last); end
        checks++;
        if (r_res !== N_OUT || r_done !== 1 || r_err !== 0) begin
            errors++; $display("FAIL basic_done res=%0d done=%0d err=%0d required %0d 1 0", r_res, r_done, r_err, N_OUT);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL basic_after done=%0b busy=%0b m_valid=%0b required 0 0 0", done, busy, m_valid);
        end
    endtask

    task automatic test_gaps();
        set_cfg(1, -7, 12345, 1, 0, 0, 0);
        cfg_y = '{-32'sd100, 32'sd1, 32'sd2, 32'sh7fffffff};
        run_job();
        checks++;
        if (r_wr !== N_WORDS || r_last_addr !== N_WORDS - 1 || r_done !== 1) begin
            errors++; $display("FAIL gaps writes=%0d last=%0d done=%0d required %0d %0d 1", r_wr, r_last_addr, r_done, N_WORDS, N_WORDS - 1);
        end
    endtask

    task automatic test_backpressure();
        set_cfg(0, 3, -100, 1, 2, 5, 0);
        cfg_y = '{32'sd5, 32'sd0, 32'sd17, -32'sd1};
        run_job();
        checks++;
        if (r_hold !== 5 || r_hold_first !== 32'sd17 || r_hold_last !== 32'sd17) begin
            errors++; $display("FAIL bp_hold cycles=%0d first=%0d last=%0d required 5 17 17", r_hold, r_hold_first, r_hold_last);
        end
        checks++;
        if (r_res !== N_OUT || r_done !== 1) begin
            errors++; $display("FAIL bp_count res=%0d done=%0d required %0d 1", r_res, r_done, N_OUT);
        end
    endtask

    task automatic test_timeout();
        set_cfg(0, 5, 1, 0, 0, 0, 0);
        run_job();
        checks++;
        if (r_err !== 1 || r_err_cyc - r_wr_cyc !== TIMEOUT) begin
            errors++; $display("FAIL timeout_err count=%0d delay=%0d required 1 %0d", r_err, r_err_cyc - r_wr_cyc, TIMEOUT);
        end
        checks++;
        if (r_mvalid !== 0 || r_done !== 0 || r_err_rst !== 1'b1 || r_rst_all !== RST_CYCLES + 1) begin
            errors++; $display("FAIL timeout_side mvalid=%0d done=%0d err_rst=%0b rst_cycles=%0d required 0 0 1 %0d",
                               r_mvalid, r_done, r_err_rst, r_rst_all, RST_CYCLES + 1);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || acc_rst !== 1'b0) begin
            errors++; $display("FAIL timeout_after err=%0b busy=%0b acc_rst=%0b required 0 0 0", err, busy, acc_rst);
        end
    endtask

    task automatic test_reset_mid_load();
        int n, i, c, bad;
        n = 0; i = 0; c = 0; bad = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (n < 40 && c < BUDGET) begin
            s_valid = 1'b1; s_data = i * 3 - 100;
            @(negedge clk);
            if (acc_we) n++;
            if (n == 40) begin
                rst = 1'b1;
            end else begin
                if (s_valid && s_ready) begin
                    drv_w.addr = i; drv_w.data = s_data;
                    exp_wr.push_back(drv_w); i++;
                end
                @(posedge clk); #1;
                c++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (n !== 40) begin errors++; $display("FAIL midrst_reach writes=%0d required 40", n); end
        checks++;
        if ({s_ready, acc_rst, acc_we, m_valid, m_last, busy, done, err} !== 8'h00 || acc_addr !== 8'd0 || acc_data_in !== '0) begin
            errors++; $display("FAIL midrst_outputs ctrl=%b addr=%0d din=%0d required 0",
                               {s_ready, acc_rst, acc_we, m_valid, m_last, busy, done, err}, acc_addr, acc_data_in);
        end
        checks++;
        if (exp_wr.size() !== 0) begin errors++; $display("FAIL midrst_pending got=%0d required=0", exp_wr.size()); end
        exp_wr.delete();
        rst = 1'b0; s_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (acc_we || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL midrst_quiet active_cycles=%0d required=0", bad); end
        set_cfg(0, 11, -3, 1, 0, 0, 0);
        cfg_y = '{32'sd9, -32'sd9, 32'sd90, -32'sd90};
        run_job();
        checks++;
        if (r_wr !== N_WORDS || r_lat !== RST_CYCLES + 2 || r_done !== 1) begin
            errors++; $display("FAIL midrst_rerun writes=%0d lat=%0d done=%0d required %0d %0d 1", r_wr, r_lat, r_done, N_WORDS, RST_CYCLES + 2);
        end
    endtask

    task automatic test_back_to_back();
        set_cfg(0, 2, 0, 1, 0, 0, 1);
        cfg_y = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
        run_job();
        checks++;
        if (r_wr !== N_WORDS || r_rst_all !== RST_CYCLES || r_done !== 1) begin
            errors++; $display("FAIL ignored_start writes=%0d rst_cycles=%0d done=%0d required %0d %0d 1", r_wr, r_rst_all, r_done, N_WORDS, RST_CYCLES);
        end
        set_cfg(0, -1, 500, 1, 0, 0, 0);
        cfg_y = '{-32'sd5, 32'sh7fffffff, 32'sh80000000, 32'sd9};
        run_job();
        checks++;
        if (r_wr !== N_WORDS || r_rst_all !== RST_CYCLES || r_lat !== RST_CYCLES + 2 || r_res !== N_OUT) begin
            errors++; $display("FAIL second_job writes=%0d rst_cycles=%0d lat=%0d res=%0d required %0d %0d %0d %0d",
                               r_wr, r_rst_all, r_lat, r_res, N_WORDS, RST_CYCLES, RST_CYCLES + 2, N_OUT);
        end
    endtask

    task automatic test_drain();
        checks++;
        if (exp_wr.size() !== 0 || exp_res.size() !== 0) begin
            errors++; $display("FAIL scoreboard_left writes=%0d results=%0d required 0 0", exp_wr.size(), exp_res.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        acc_data_out = '0; acc_data_valid = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_timeout();
        test_reset_mid_load();
        test_back_to_back();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t required bench completion", $time);
        $fatal(1);
    end
endmodule

// File: doc/gan_host_driver.md
Name: gan_host_driver

Overview:
- Host-side driver for the GAN inference core's word-addressed load port.
- Accepts the 77 parameter words (x[0..3], w[0..53], b[0..18]) as a valid/ready stream and drives the core's addr/we/data_in write sequence.
- Detects completion, captures the core's four serial output words, and replays them as a valid/ready result stream with a last flag.
- Sits between the system bus/DMA and the inference core; one job per start pulse.

Parameters:
- WIDTH, 32, data word width (matches core).
- N_WORDS, 77, parameter words per job; written to core addresses 0..N_WORDS-1.
- N_OUT, 4, output words captured per job.
- RST_CYCLES, 2, cycles acc_rst is held at job start.
- TIMEOUT, 1024, max cycles from last write to result capture.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle job request; honoured only in IDLE
- s_data  in  WIDTH  parameter word, signed
- s_valid  in  1  parameter word valid
- s_ready  out  1  driver accepts parameter word
- acc_rst  out  1  reset to core
- acc_data_in  out  WIDTH  write data to core
- acc_addr  out  8  write address to core
- acc_we  out  1  write enable to core
- acc_data_out  in  WIDTH  core output word
- acc_data_valid  in  1  core output-complete flag
- m_data  out  WIDTH  result word
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_last  out  1  marks result word N_OUT-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last result is accepted
- err  out  1  one-cycle pulse on timeout

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; state IDLE; counters and capture registers cleared. Reset mid-job aborts immediately; no further acc_we.
- All outputs are registered.
- States: IDLE, RST_ACC, LOAD, WAIT_LOW, WAIT_EDGE, OUTPUT.
- IDLE:
  - start=1 -> RST_ACC.
  - Word counter cleared.
  - start in any other state is ignored.
- RST_ACC:
  - acc_rst=1 for exactly RST_CYCLES cycles, then LOAD.
- LOAD:
  - s_ready=1.
  - On s_valid&s_ready, the next cycle has acc_we=1, acc_addr=counter, acc_data_in=s_data; the counter then increments.
  - acc_we=0 on cycles without a transfer; acc_addr/acc_data_in hold their last value.
  - Addresses are strictly ascending 0..N_WORDS-1 with no gaps or repeats.
  - Sustains one write per cycle.
  - On accepting word N_WORDS-1: s_ready drops the same cycle the write is issued; go to WAIT_LOW and clear the timeout counter.
- WAIT_LOW:
  - Wait for acc_data_valid=0 to arm the edge detector, then go to WAIT_EDGE.
  - Timeout counter increments.
- WAIT_EDGE:
  - Every cycle, shift acc_data_out into a 3-deep history (h0 newest).
  - When acc_data_valid=1 is sampled, latch result[3]=acc_data_out, result[2]=h0, result[1]=h1, result[0]=h2. The core presents Y0..Y3 on consecutive cycles with the flag rising alongside Y3.
  - Go to OUTPUT with index 0.
- Timeout:
  - If the counter reaches TIMEOUT in WAIT_LOW or WAIT_EDGE: err=1 for one cycle, acc_rst pulses, return to IDLE; no result words are emitted.
- OUTPUT:
  - m_valid=1, m_data=result[index], m_last=(index==N_OUT-1).
  - Advance on m_valid&m_ready; m_data is stable while m_ready=0.
  - After word N_OUT-1 is accepted: m_valid=0, done=1 for one cycle, go to IDLE.
- Arithmetic: no arithmetic on data; words pass bit-exact, signed values preserved.
- Latency:
  - start to first acc_we: RST_CYCLES+2 cycles, given s_valid held high.
  - Capture to m_valid: 1 cycle.

Test Plan:
- Basic job: start, stream words 0..76 with data=addr*3-100, s_valid held high, core model emits Y={5,0,17,-1} -> 77 acc_we pulses at addr 0..76 with matching data; m_data 5,0,17,-1 (-1 stays signed); m_last on the 4th word; done pulses once.
- Upstream gaps: s_valid toggles 1,0,0,1 pattern -> acc_we only on accepted words; no address skipped or repeated; final addr 76.
- Downstream backpressure: m_ready low for 5 cycles on word 2 -> m_data holds 17 and m_valid stays high; no word lost or duplicated.
- Timeout: core model never asserts acc_data_valid -> err pulses 1024 cycles after the last write; state returns to IDLE; m_valid never asserted.
- Reset mid-load: rst asserted after the 40th write -> next cycle all outputs 0; a subsequent start runs a clean job from addr 0.
- Ignored start and back-to-back jobs: start pulsed during LOAD -> no effect; a second job after done produces a fresh acc_rst pulse of 2 cycles and correct new results.
